// File: rtl/pump_control.sv
// Pump sequencing FSM for the filter tank: fills on low level, stops on full,
// guards against dry-run with a fill timeout and latches faults until cleared.
module pump_control #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int MAX_FILL_MS = 120_000,
    parameter int MIN_OFF_MS  = 5_000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_enable,
    input  logic        i_level_low,
    input  logic        i_level_high,
    input  logic        i_fault_clear,
    output logic        o_pump_on,
    output logic        o_fault,
    output logic [1:0]  o_fault_code,
    output logic [15:0] o_fill_count
);

    // Timing is built from a ms tick so no clock-count product is ever formed.
    localparam int TICKS  = CLK_FREQ / 1000;
    localparam int PW     = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam int MAX_MS = (MAX_FILL_MS > MIN_OFF_MS) ? MAX_FILL_MS : MIN_OFF_MS;
    localparam int MW     = $clog2(MAX_MS + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(TICKS - 1);
    localparam logic [MW-1:0] FILL_LAST = MW'(MAX_FILL_MS - 1);
    localparam logic [MW-1:0] OFF_LAST  = MW'(MIN_OFF_MS - 1);

    localparam logic [1:0] CODE_NONE    = 2'b00;
    localparam logic [1:0] CODE_TIMEOUT = 2'b01;
    localparam logic [1:0] CODE_SENSOR  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        LOCKOUT = 2'd2,
        FAULT   = 2'd3
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_prescale;
    logic [MW-1:0]   r_msCnt;
    logic [1:0]      r_faultCode;
    logic [15:0]     r_fillCount;

    logic w_inconsistent;
    logic w_tick;
    logic w_fillDone;
    logic w_offDone;

    assign w_inconsistent = i_level_low & ~i_level_high;
    assign w_tick         = (r_prescale == PRE_LAST);
    assign w_fillDone     = w_tick && (r_msCnt == FILL_LAST);
    assign w_offDone      = w_tick && (r_msCnt == OFF_LAST);

    // Transition branches clear the timebase after the run/hold update, so the
    // later non-blocking write wins and every new state starts from zero.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state     <= IDLE;
            r_prescale  <= '0;
            r_msCnt     <= '0;
            r_faultCode <= CODE_NONE;
            r_fillCount <= '0;
        end else begin
            if (r_state == FILL || r_state == LOCKOUT) begin
                if (w_tick) begin
                    r_prescale <= '0;
                    r_msCnt    <= r_msCnt + MW'(1);
                end else begin
                    r_prescale <= r_prescale + PW'(1);
                end
            end else begin
                r_prescale <= '0;
                r_msCnt    <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_inconsistent) begin
                        r_state     <= FAULT;
                        r_faultCode <= CODE_SENSOR;
                        r_prescale  <= '0;
                        r_msCnt     <= '0;
                    end else if (i_enable && i_level_low) begin
                        r_state    <= FILL;
                        r_prescale <= '0;
                        r_msCnt    <= '0;
                    end
                end

                FILL: begin
                    if (w_inconsistent) begin
                        r_state     <= FAULT;
                        r_faultCode <= CODE_SENSOR;
                        r_prescale  <= '0;
                        r_msCnt     <= '0;
                    end else if (!i_level_high) begin
                        r_state    <= LOCKOUT;
                        r_prescale <= '0;
                        r_msCnt    <= '0;
                        if (r_fillCount != 16'hFFFF) begin
                            r_fillCount <= r_fillCount + 16'd1;
                        end
                    end else if (!i_enable) begin
                        r_state    <= LOCKOUT;
                        r_prescale <= '0;
                        r_msCnt    <= '0;
                    end else if (w_fillDone) begin
                        r_state     <= FAULT;
                        r_faultCode <= CODE_TIMEOUT;
                        r_prescale  <= '0;
                        r_msCnt     <= '0;
                    end
                end

                LOCKOUT: begin
                    if (w_inconsistent) begin
                        r_state     <= FAULT;
                        r_faultCode <= CODE_SENSOR;
                        r_prescale  <= '0;
                        r_msCnt     <= '0;
                    end else if (w_offDone) begin
                        r_state    <= IDLE;
                        r_prescale <= '0;
                        r_msCnt    <= '0;
                    end
                end

                FAULT: begin
                    // A clear seen with inconsistent sensors is simply dropped.
                    if (i_fault_clear && !w_inconsistent) begin
                        r_state     <= LOCKOUT;
                        r_faultCode <= CODE_NONE;
                        r_prescale  <= '0;
                        r_msCnt     <= '0;
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_pump_on    = (r_state == FILL);
    assign o_fault      = (r_state == FAULT);
    assign o_fault_code = r_faultCode;
    assign o_fill_count = r_fillCount;

endmodule

// File: tb/tb_pump_control.sv
// Directed testbench for pump_control with 10 clocks per ms, a 500-cycle fill
// limit and a 200-cycle lockout; inputs change and outputs are sampled on negedge.
module tb_pump_control;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        levelLow;
    logic        levelHigh;
    logic        faultClear;
    logic        pumpOn;
    logic        fault;
    logic [1:0]  faultCode;
    logic [15:0] fillCount;

    int checks   = 0;
    int failures = 0;
    int runLen;

    pump_control #(
        .CLK_FREQ   (10_000),
        .MAX_FILL_MS(50),
        .MIN_OFF_MS (20)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_enable     (enable),
        .i_level_low  (levelLow),
        .i_level_high (levelHigh),
        .i_fault_clear(faultClear),
        .o_pump_on    (pumpOn),
        .o_fault      (fault),
        .o_fault_code (faultCode),
        .o_fill_count (fillCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic en, input logic low, input logic high);
        enable    = en;
        levelLow  = low;
        levelHigh = high;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic waitNeg(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts pump_on samples until fault rises, bounded so a stuck DUT cannot hang the run.
    task automatic measureRun(output int len);
        len = 0;
        for (int i = 0; i < 700; i++) begin
            if (pumpOn) len++;
            if (fault) break;
            @(negedge clk);
        end
    endtask

    initial begin
        reset      = 1'b1;
        faultClear = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitNeg(2);

        // Reset defaults
        checkOutput("rst_pump", pumpOn, 0);
        checkOutput("rst_fault", fault, 0);
        checkOutput("rst_code", faultCode, 0);
        checkOutput("rst_count", fillCount, 0);
        reset = 1'b0;
        #1 checkOutput("rel_pump_before_edge", pumpOn, 0);
        waitNeg(1);
        checkOutput("first_fill_pump", pumpOn, 1);

        // Normal fill ended by full
        waitNeg(99);
        checkOutput("fill_100_pump", pumpOn, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(1);
        checkOutput("full_pump_off", pumpOn, 0);
        checkOutput("full_count", fillCount, 1);
        checkOutput("full_no_fault", fault, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitNeg(200);
        checkOutput("lockout_200_pump", pumpOn, 0);
        waitNeg(1);
        checkOutput("lockout_201_pump", pumpOn, 1);

        // Timeout after exactly 500 pump cycles
        measureRun(runLen);
        checkOutput("timeout_run_len", 16'(runLen), 500);
        checkOutput("timeout_fault", fault, 1);
        checkOutput("timeout_code", faultCode, 2'b01);
        checkOutput("timeout_pump", pumpOn, 0);
        checkOutput("timeout_count", fillCount, 1);
        enable = 1'b0;
        waitNeg(3);
        enable = 1'b1;
        waitNeg(3);
        checkOutput("fault_ignores_en", fault, 1);
        checkOutput("fault_ignores_en_code", faultCode, 2'b01);

        // Clear with inconsistent sensors is dropped and not remembered
        applyStimulus(1'b1, 1'b1, 1'b0);
        faultClear = 1'b1;
        waitNeg(1);
        faultClear = 1'b0;
        applyStimulus(1'b1, 1'b0, 1'b1);
        waitNeg(2);
        checkOutput("clear_dropped_fault", fault, 1);
        checkOutput("clear_dropped_code", faultCode, 2'b01);
        faultClear = 1'b1;
        waitNeg(1);
        faultClear = 1'b0;
        checkOutput("clear_fault", fault, 0);
        checkOutput("clear_code", faultCode, 0);
        checkOutput("clear_pump", pumpOn, 0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitNeg(200);
        checkOutput("clear_lockout_200", pumpOn, 0);
        waitNeg(1);
        checkOutput("clear_lockout_201", pumpOn, 1);

        // Full on the same edge as timeout: full wins
        waitNeg(499);
        checkOutput("fill_500_pump", pumpOn, 1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        waitNeg(1);
        checkOutput("simul_pump", pumpOn, 0);
        checkOutput("simul_fault", fault, 0);
        checkOutput("simul_count", fillCount, 2);
        checkOutput("simul_code", faultCode, 0);

        // Asynchronous reset 250 cycles into a fill
        applyStimulus(1'b1, 1'b1, 1'b1);
        waitNeg(201);
        checkOutput("refill_pump", pumpOn, 1);
        waitNeg(249);
        checkOutput("fill_250_pump", pumpOn, 1);
        #2 reset = 1'b1;
        #1 checkOutput("async_rst_pump", pumpOn, 0);
        checkOutput("async_rst_count", fillCount, 0);
        waitNeg(1);
        reset = 1'b0;
        waitNeg(1);
        measureRun(runLen);
        checkOutput("post_rst_run_len", 16'(runLen), 500);
        checkOutput("post_rst_code", faultCode, 2'b01);

        // Sensor inconsistency seen in IDLE
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b1);
        waitNeg(1);
        reset = 1'b0;
        waitNeg(2);
        checkOutput("idle_pump", pumpOn, 0);
        checkOutput("idle_fault", fault, 0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        waitNeg(1);
        checkOutput("incons_fault", fault, 1);
        checkOutput("incons_code", faultCode, 2'b10);
        checkOutput("incons_pump", pumpOn, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
